// File: rtl/rat_checkpoint_buffer.sv
// Circular checkpoint queue of register-alias-table tag images. Captures on branch
// issue, scrubs completed tags from the CDB, and restores the oldest image on a mispredict.
module rat_checkpoint_buffer #(
    parameter int NUM_SRBITS = 8,
    parameter int DEPTH      = 4,
    parameter int PTR_W      = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    snap_req,
    input  logic [31*NUM_SRBITS-1:0] all_tags_bus,
    output logic [PTR_W-1:0]        snap_id,
    output logic                    full,
    output logic                    empty,
    output logic [PTR_W:0]          count,
    input  logic                    resolve_valid,
    input  logic [PTR_W-1:0]        resolve_id,
    input  logic                    resolve_mispredict,
    input  logic [40:0]             cdb,
    output logic                    restore,
    output logic [31*NUM_SRBITS-1:0] restore_tags_bus,
    output logic                    err
);

    localparam int IMG_W = 31 * NUM_SRBITS;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    // Clears every tag field that equals the broadcast tag; tag 0 never matches.
    function automatic logic [IMG_W-1:0] scrub(
        input logic [IMG_W-1:0]      img,
        input logic                  hit_en,
        input logic [NUM_SRBITS-1:0] tag
    );
        logic [IMG_W-1:0] res;
        res = img;
        for (int f = 0; f < 31; f++) begin
            if (hit_en && (img[f*NUM_SRBITS +: NUM_SRBITS] == tag)) begin
                res[f*NUM_SRBITS +: NUM_SRBITS] = '0;
            end else begin
                res[f*NUM_SRBITS +: NUM_SRBITS] = img[f*NUM_SRBITS +: NUM_SRBITS];
            end
        end
        return res;
    endfunction

    logic [IMG_W-1:0]      slots_r [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [PTR_W:0]        count_r;
    logic                  restore_r;
    logic [IMG_W-1:0]      restore_tags_r;
    logic                  err_r;

    logic [NUM_SRBITS-1:0] cdb_tag_s;
    logic                  hit_en_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  resolve_ok_s;
    logic                  mispredict_s;
    logic                  correct_s;
    logic                  capture_s;
    logic                  err_s;
    logic [PTR_W-1:0]      wr_ptr_n_s;
    logic [PTR_W-1:0]      rd_ptr_n_s;
    logic [PTR_W:0]        count_n_s;
    logic                  occupied_s [DEPTH];
    logic                  unused_s;

    assign cdb_tag_s = cdb[32 +: NUM_SRBITS];
    assign hit_en_s  = cdb[40] && (cdb_tag_s != '0);
    assign full_s    = (count_r == DEPTH_C);
    assign empty_s   = (count_r == '0);
    assign unused_s  = ^cdb[31:0];

    // Control decode: resolve acceptance, capture qualification and error detection.
    always_comb begin
        resolve_ok_s = 1'b0;
        mispredict_s = 1'b0;
        correct_s    = 1'b0;
        capture_s    = 1'b0;
        err_s        = 1'b0;
        if (resolve_valid) begin
            if (!empty_s && (resolve_id == rd_ptr_r)) begin
                resolve_ok_s = 1'b1;
            end else begin
                err_s = 1'b1;
            end
        end else begin
            resolve_ok_s = 1'b0;
        end
        mispredict_s = resolve_ok_s && resolve_mispredict;
        correct_s    = resolve_ok_s && !resolve_mispredict;
        // A slot freed by an in-order commit in the same cycle can take the new capture.
        if (snap_req && !mispredict_s) begin
            if (!full_s || correct_s) begin
                capture_s = 1'b1;
            end else begin
                err_s = 1'b1;
            end
        end else begin
            capture_s = 1'b0;
        end
    end

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_n_s = wr_ptr_r;
        rd_ptr_n_s = rd_ptr_r;
        count_n_s  = count_r;
        if (mispredict_s) begin
            wr_ptr_n_s = rd_ptr_r;
            count_n_s  = '0;
        end else begin
            if (capture_s) begin
                wr_ptr_n_s = wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_n_s = wr_ptr_r;
            end
            if (correct_s) begin
                rd_ptr_n_s = rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_n_s = rd_ptr_r;
            end
            case ({capture_s, correct_s})
                2'b10:   count_n_s = count_r + (PTR_W + 1)'(1);
                2'b01:   count_n_s = count_r - (PTR_W + 1)'(1);
                default: count_n_s = count_r;
            endcase
        end
    end

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            occupied_s[i] = ({1'b0, PTR_W'(i) - rd_ptr_r} < count_r);
        end
    end

    // Pointer, count and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r       <= '0;
            rd_ptr_r       <= '0;
            count_r        <= '0;
            restore_r      <= 1'b0;
            restore_tags_r <= '0;
            err_r          <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_n_s;
            rd_ptr_r <= rd_ptr_n_s;
            count_r  <= count_n_s;
            err_r    <= err_s;
            if (mispredict_s) begin
                restore_r      <= 1'b1;
                restore_tags_r <= scrub(slots_r[rd_ptr_r], hit_en_s, cdb_tag_s);
            end else begin
                restore_r      <= 1'b0;
                restore_tags_r <= restore_tags_r;
            end
        end
    end

    // Slot storage: capture with CDB bypass, otherwise scrub live slots; free slots keep stale data.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (capture_s && (wr_ptr_r == PTR_W'(i))) begin
                slots_r[i] <= scrub(all_tags_bus, hit_en_s, cdb_tag_s);
            end else if (occupied_s[i]) begin
                slots_r[i] <= scrub(slots_r[i], hit_en_s, cdb_tag_s);
            end else begin
                slots_r[i] <= slots_r[i];
            end
        end
    end

    assign snap_id          = wr_ptr_r;
    assign full             = full_s;
    assign empty            = empty_s;
    assign count            = count_r;
    assign restore          = restore_r;
    assign restore_tags_bus = restore_tags_r;
    assign err              = err_r;

endmodule

// File: doc/rat_checkpoint_buffer.md
Name: rat_checkpoint_buffer

Overview:
- Writer side of the register-alias-table snapshot/restore interface of taggedRegs.
- On each branch issue it captures all_tags_bus into a circular checkpoint queue.
- While a checkpoint is held, it keeps the checkpoint current by clearing any tag broadcast on the CDB.
- On a mispredicted branch it drives the restore / restore_tags_bus pair back into taggedRegs and squashes all younger checkpoints.
- Sits between the issue stage, JumpHandle (branch resolution) and taggedRegs.

Parameters:
- NUM_SRBITS, 8: tag width per architectural register. Equals `NUM_SRBITS.
- DEPTH, 4: number of checkpoint slots. Must be a power of two, at least 2.
- PTR_W, 2: log2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- snap_req  input  1  a branch or ujump issues this cycle; capture a checkpoint.
- all_tags_bus  input  31*NUM_SRBITS  current tags of x1..x31. Field i-1 holds the tag of register xi.
- snap_id  output  PTR_W  slot that a snap_req in this cycle is written to (equals wr_ptr, combinational).
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  PTR_W+1  number of occupied slots.
- resolve_valid  input  1  the oldest outstanding branch resolves this cycle.
- resolve_id  input  PTR_W  id of the resolving checkpoint.
- resolve_mispredict  input  1  qualifies resolve_valid: 1 = mispredicted, 0 = correctly predicted.
- cdb  input  41  cdb[40] valid, cdb[39:32] tag, cdb[31:0] data (data is unused here).
- restore  output  1  one-cycle pulse: taggedRegs loads restore_tags_bus.
- restore_tags_bus  output  31*NUM_SRBITS  checkpoint image being restored.
- err  output  1  one-cycle pulse on a protocol violation.

Behaviour:
- Reset (asynchronous):
  - wr_ptr = rd_ptr = 0, count = 0, so empty = 1 and full = 0.
  - restore = 0, restore_tags_bus = 0, err = 0.
  - Slot contents are don't-care.
- Tag 0 means the register is ready. A CDB tag of 0 never matches any field.
- CDB scrub, every cycle with cdb[40] = 1:
  - In every occupied slot, each NUM_SRBITS field equal to cdb[39:32] is cleared to 0.
  - Free slots are not touched.
- Capture: when snap_req = 1, count < DEPTH, and no mispredict is accepted this cycle:
  - slot[wr_ptr] <= all_tags_bus, with any field matching a valid CDB tag in the same cycle already cleared (bypass).
  - wr_ptr increments mod DEPTH; count increments.
- snap_req while full: dropped, err pulses the next cycle, no state change. The issue stage stalls on full.
- Resolution is in order. A resolve with resolve_id != rd_ptr, or any resolve while empty, is ignored and err pulses.
- Correct prediction (resolve_valid = 1, resolve_mispredict = 0): rd_ptr increments and count decrements.
  - Together with a valid capture in the same cycle, count is unchanged and both pointers advance.
- Misprediction (resolve_valid = 1, resolve_mispredict = 1):
  - Next cycle: restore = 1 for exactly one cycle, and restore_tags_bus = slot[rd_ptr] with the same-cycle CDB match applied.
  - All slots are squashed: wr_ptr <= rd_ptr, count <= 0.
  - A snap_req in the same cycle is discarded (the instruction is on the wrong path) and does not raise err.
- restore_tags_bus holds its last restored image until the next restore or reset.
  - A CDB broadcast in the cycle restore is high is not applied to this image; taggedRegs handles that same-cycle broadcast itself.
- Pointer wrap-around: wrap mod DEPTH, with no lost or duplicate slot when full or empty is reached by wrapping.
- Reset during a pending restore: reset wins, and restore stays 0.
- Latency:
  - Capture is visible in count 1 cycle after snap_req.
  - restore is asserted 1 cycle after a mispredict resolve.

Test Plan:
1. Reset, then snap_req with all_tags_bus field x1 = 0x81 and x2 = 0x84. Expect snap_id = 0, then count = 1 and empty = 0 on the next cycle.
2. After scenario 1, drive cdb = {1'b1, 8'h81, 32'h48}, then resolve id 0 with mispredict. Expect restore = 1 for one cycle with x1 field = 0x00 and x2 field = 0x84; then count = 0 and empty = 1.
3. Fill 4 slots. A 5th snap_req pulses err and count stays 4. Resolve-correct id 0 together with snap_req: count stays 4, snap_id wraps to 0.
4. Drive snap_req and a CDB valid with tag 0x82 in the same cycle while all_tags_bus x3 = 0x82. Then mispredict resolve. The restored x3 field = 0x00.
5. Three checkpoints outstanding. Resolve id 1 (not the oldest): err pulses, no change. Resolve id 0 with mispredict: all three squashed, count = 0, restore pulses once; a snap_req in that cycle is ignored.
6. Assert rst asynchronously in the cycle after a mispredict resolve. Expect restore = 0 and restore_tags_bus = 0 immediately, count = 0.
